// File: rtl/disp_adapt_pkg.sv
// Shared display-adapter codes: narrowing modes and the 2x2 Bayer ordering.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package disp_adapt_pkg;

    localparam int DISP_MODE_TRUNC  = 0;
    localparam int DISP_MODE_ROUND  = 1;
    localparam int DISP_MODE_DITHER = 2;

    // Bayer rank from pixel parity: (0,0)->0, (1,0)->2, (0,1)->3, (1,1)->1
    function automatic logic [1:0] disp_bayer(input logic x0, input logic y0);
        return {x0 ^ y0, y0};
    endfunction

endpackage

// File: rtl/disp_chan_conv.sv
// Single colour channel width converter: replicate, pass, truncate, round or dither.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module disp_chan_conv
    import disp_adapt_pkg::*;
#(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8,
    parameter int MODE    = DISP_MODE_TRUNC
) (
    input  logic [BPC_IN-1:0]  c,
    input  logic               x0,
    input  logic               y0,
    output logic [BPC_OUT-1:0] o
);

    generate
        if (BPC_OUT > BPC_IN) begin : g_widen
            logic unused_xy;
            assign unused_xy = x0 ^ y0;

            // Repeat the input MSB-first so 0 stays 0 and all-ones stays all-ones
            always_comb begin
                o = '0;
                for (int i = 0; i < BPC_OUT; i++) begin
                    o[BPC_OUT-1-i] = c[BPC_IN-1-(i % BPC_IN)];
                end
            end
        end else if (BPC_OUT == BPC_IN) begin : g_pass
            logic unused_xy;
            assign unused_xy = x0 ^ y0;
            assign o = c;
        end else begin : g_narrow
            localparam int D  = BPC_IN - BPC_OUT;
            localparam int SH = (D >= 2) ? D - 2 : 0;

            logic [1:0]      bay;
            logic [BPC_IN:0] add;
            logic [BPC_IN:0] sum;
            logic            unused_lo;

            // Pick the bias added before the low D bits are dropped; unknown modes truncate
            always_comb begin
                bay = disp_bayer(x0, y0);
                add = '0;
                if (MODE == DISP_MODE_ROUND) begin
                    add = (BPC_IN+1)'(1) << (D - 1);
                end else if (MODE == DISP_MODE_DITHER) begin
                    if (D >= 2) begin
                        add = (BPC_IN+1)'(bay) << SH;
                    end else begin
                        add = (BPC_IN+1)'(bay >> 1);
                    end
                end
            end

            // One spare bit catches the carry so the result saturates instead of wrapping
            assign sum       = {1'b0, c} + add;
            assign o         = sum[BPC_IN] ? '1 : sum[BPC_IN-1:D];
            assign unused_lo = ^{sum[D-1:0], bay};
        end
    endgenerate

endmodule

// File: rtl/disp_adapt.sv
// Display output adapter: per-channel width conversion, aligned sync delay, frame checksum.
// Latency: PIPE clk_pix cycles for every out_*; frame stats update one cycle after out_frame.
// Backpressure: none; free-running pixel stream, one pixel accepted every cycle.
module disp_adapt
    import disp_adapt_pkg::*;
#(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8,
    parameter int CORDW   = 16,
    parameter int PIPE    = 2,
    parameter int MODE    = DISP_MODE_DITHER
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic signed [CORDW-1:0] in_x,
    input  logic signed [CORDW-1:0] in_y,
    input  logic                    in_de,
    input  logic                    in_frame,
    input  logic [BPC_IN-1:0]       in_r,
    input  logic [BPC_IN-1:0]       in_g,
    input  logic [BPC_IN-1:0]       in_b,
    output logic signed [CORDW-1:0] out_x,
    output logic signed [CORDW-1:0] out_y,
    output logic                    out_de,
    output logic                    out_frame,
    output logic [BPC_OUT-1:0]      out_r,
    output logic [BPC_OUT-1:0]      out_g,
    output logic [BPC_OUT-1:0]      out_b,
    output logic [15:0]             frame_count,
    output logic [31:0]             frame_sum,
    output logic                    sum_valid
);

    logic [BPC_OUT-1:0] cr, cg, cb;

    disp_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .MODE(MODE)) u_conv_r (
        .c(in_r), .x0(in_x[0]), .y0(in_y[0]), .o(cr)
    );
    disp_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .MODE(MODE)) u_conv_g (
        .c(in_g), .x0(in_x[0]), .y0(in_y[0]), .o(cg)
    );
    disp_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .MODE(MODE)) u_conv_b (
        .c(in_b), .x0(in_x[0]), .y0(in_y[0]), .o(cb)
    );

    logic signed [CORDW-1:0] px  [PIPE];
    logic signed [CORDW-1:0] py  [PIPE];
    logic                    pde [PIPE];
    logic                    pfr [PIPE];
    logic [BPC_OUT-1:0]      pr  [PIPE];
    logic [BPC_OUT-1:0]      pg  [PIPE];
    logic [BPC_OUT-1:0]      pb  [PIPE];

    // Stage 0 captures converted, blanked colour; later stages are plain delay
    always_ff @(posedge clk_pix or negedge rst_pix) begin
        if (!rst_pix) begin
            for (int i = 0; i < PIPE; i++) begin
                px[i]  <= '0;
                py[i]  <= '0;
                pde[i] <= 1'b0;
                pfr[i] <= 1'b0;
                pr[i]  <= '0;
                pg[i]  <= '0;
                pb[i]  <= '0;
            end
        end else begin
            px[0]  <= in_x;
            py[0]  <= in_y;
            pde[0] <= in_de;
            pfr[0] <= in_frame;
            pr[0]  <= in_de ? cr : '0;
            pg[0]  <= in_de ? cg : '0;
            pb[0]  <= in_de ? cb : '0;
            for (int i = 1; i < PIPE; i++) begin
                px[i]  <= px[i-1];
                py[i]  <= py[i-1];
                pde[i] <= pde[i-1];
                pfr[i] <= pfr[i-1];
                pr[i]  <= pr[i-1];
                pg[i]  <= pg[i-1];
                pb[i]  <= pb[i-1];
            end
        end
    end

    assign out_x     = px[PIPE-1];
    assign out_y     = py[PIPE-1];
    assign out_de    = pde[PIPE-1];
    assign out_frame = pfr[PIPE-1];
    assign out_r     = pr[PIPE-1];
    assign out_g     = pg[PIPE-1];
    assign out_b     = pb[PIPE-1];

    logic [31:0] acc;
    logic [31:0] pix_sum;
    logic        primed;

    assign pix_sum = out_de ? (32'(out_r) + 32'(out_g) + 32'(out_b)) : 32'd0;

    // Accumulate visible pixels; on each frame start publish the previous frame (once primed)
    always_ff @(posedge clk_pix or negedge rst_pix) begin
        if (!rst_pix) begin
            acc         <= '0;
            primed      <= 1'b0;
            frame_count <= '0;
            frame_sum   <= '0;
            sum_valid   <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (out_frame) begin
                frame_count <= frame_count + 16'd1;
                // A back-to-back frame pulse never stretches sum_valid to two cycles
                if (primed && !sum_valid) begin
                    frame_sum <= acc;
                    sum_valid <= 1'b1;
                end
                acc    <= pix_sum;
                primed <= 1'b1;
            end else if (out_de) begin
                acc <= acc + pix_sum;
            end
        end
    end

endmodule

// File: tb/tb_disp_adapt.sv
// Bench for disp_adapt: six builds driven in parallel, scoreboarded against a reference model.
// Latency: each build checked exactly PIPE cycles after stimulus.
// Backpressure: none.
module tb_disp_adapt;
    import disp_adapt_pkg::*;

    localparam int N = 6;

    // Build table: 0:5->8 P1, 1:5->8 P3, 2:8->5 round P2, 3:8->5 trunc P2, 4:8->5 dither P2, 5:3->8 P1
    function automatic int p_bi(int k);
        case (k)
            2, 3, 4: return 8;
            5:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int p_bo(int k);
        case (k)
            2, 3, 4: return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int p_mode(int k);
        case (k)
            2:       return DISP_MODE_ROUND;
            4:       return DISP_MODE_DITHER;
            default: return DISP_MODE_TRUNC;
        endcase
    endfunction

    function automatic int p_pipe(int k);
        case (k)
            1:       return 3;
            2, 3, 4: return 2;
            default: return 1;
        endcase
    endfunction

    logic clk_pix = 1'b0;
    logic rst_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic signed [15:0] in_x, in_y;
    logic               in_de, in_frame;
    logic [11:0]        drv_r, drv_g, drv_b;

    logic [15:0] obs_x  [N];
    logic [15:0] obs_y  [N];
    logic        obs_de [N];
    logic        obs_fr [N];
    logic        obs_sv [N];
    logic [11:0] obs_r  [N];
    logic [11:0] obs_g  [N];
    logic [11:0] obs_b  [N];
    logic [15:0] obs_fc [N];
    logic [31:0] obs_fs [N];

    generate
        for (genvar k = 0; k < N; k++) begin : g_dut
            localparam int BI = p_bi(k);
            localparam int BO = p_bo(k);
            logic [BO-1:0] r_w, g_w, b_w;

            disp_adapt #(
                .BPC_IN(BI), .BPC_OUT(BO), .CORDW(16), .PIPE(p_pipe(k)), .MODE(p_mode(k))
            ) u_dut (
                .clk_pix(clk_pix),
                .rst_pix(rst_pix),
                .in_x(in_x),
                .in_y(in_y),
                .in_de(in_de),
                .in_frame(in_frame),
                .in_r(drv_r[BI-1:0]),
                .in_g(drv_g[BI-1:0]),
                .in_b(drv_b[BI-1:0]),
                .out_x(obs_x[k]),
                .out_y(obs_y[k]),
                .out_de(obs_de[k]),
                .out_frame(obs_fr[k]),
                .out_r(r_w),
                .out_g(g_w),
                .out_b(b_w),
                .frame_count(obs_fc[k]),
                .frame_sum(obs_fs[k]),
                .sum_valid(obs_sv[k])
            );

            assign obs_r[k] = 12'(r_w);
            assign obs_g[k] = 12'(g_w);
            assign obs_b[k] = 12'(b_w);
        end
    endgenerate

    int cyc = 0;
    always @(posedge clk_pix) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference channel conversion, written from the arithmetic definition
    function automatic int conv(int c, int bi, int bo, int mode, int x0, int y0);
        int v, d, t, bay, s;
        v = c & ((1 << bi) - 1);
        if (bo > bi) begin
            s = 0;
            for (int i = 0; i < bo; i++) s |= ((v >> (bi - 1 - (i % bi))) & 1) << (bo - 1 - i);
            return s;
        end
        if (bo == bi) return v;
        d   = bi - bo;
        t   = 0;
        bay = 2 * (x0 ^ y0) + y0;
        if (mode == DISP_MODE_ROUND) t = 1 << (d - 1);
        else if (mode == DISP_MODE_DITHER) begin
            if (d >= 2) t = bay << (d - 2);
            else        t = bay >> 1;
        end
        s = v + t;
        if (s > (1 << bi) - 1) s = (1 << bi) - 1;
        return s >> d;
    endfunction

    typedef struct {
        int          inst;
        int          due;
        logic [15:0] x, y;
        logic        de, fr;
        int          r, g, b;
    } exp_t;

    exp_t sb[$];
    logic prev_sv = 1'b0;

    // Compare every expectation that falls due this cycle; also police the sum_valid pulse width
    always @(negedge clk_pix) begin
        if (rst_pix) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    chk($sformatf("u%0d_x",  sb[i].inst), 32'(obs_x[sb[i].inst]),  32'(sb[i].x));
                    chk($sformatf("u%0d_y",  sb[i].inst), 32'(obs_y[sb[i].inst]),  32'(sb[i].y));
                    chk($sformatf("u%0d_de", sb[i].inst), 32'(obs_de[sb[i].inst]), 32'(sb[i].de));
                    chk($sformatf("u%0d_fr", sb[i].inst), 32'(obs_fr[sb[i].inst]), 32'(sb[i].fr));
                    chk($sformatf("u%0d_r",  sb[i].inst), 32'(obs_r[sb[i].inst]),  sb[i].r);
                    chk($sformatf("u%0d_g",  sb[i].inst), 32'(obs_g[sb[i].inst]),  sb[i].g);
                    chk($sformatf("u%0d_b",  sb[i].inst), 32'(obs_b[sb[i].inst]),  sb[i].b);
                    sb.delete(i);
                end
            end
            if (prev_sv) chk("sv_single_cycle", 32'(obs_sv[1]), 32'd0);
            prev_sv <= obs_sv[1];
        end else begin
            prev_sv <= 1'b0;
        end
    end

    // Drive one pixel for one cycle and queue what each build must show PIPE cycles later
    task automatic step(input int x, input int y, input bit de, input bit fr,
                        input int cr, input int cg, input int cb);
        exp_t e;
        @(negedge clk_pix);
        in_x     = 16'(x);
        in_y     = 16'(y);
        in_de    = de;
        in_frame = fr;
        drv_r    = 12'(cr);
        drv_g    = 12'(cg);
        drv_b    = 12'(cb);
        for (int k = 0; k < N; k++) begin
            e.inst = k;
            e.due  = cyc + p_pipe(k);
            e.x    = 16'(x);
            e.y    = 16'(y);
            e.de   = de;
            e.fr   = fr;
            e.r    = de ? conv(cr, p_bi(k), p_bo(k), p_mode(k), x & 1, y & 1) : 0;
            e.g    = de ? conv(cg, p_bi(k), p_bo(k), p_mode(k), x & 1, y & 1) : 0;
            e.b    = de ? conv(cb, p_bi(k), p_bo(k), p_mode(k), x & 1, y & 1) : 0;
            sb.push_back(e);
        end
    endtask

    // Hold the current pixel for n cycles without a repeated frame pulse
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_pix);
            in_frame = 1'b0;
        end
    endtask

    initial begin
        in_x = '0; in_y = '0; in_de = 1'b0; in_frame = 1'b0;
        drv_r = '0; drv_g = '0; drv_b = '0;
        rst_pix = 1'b0;
        repeat (3) @(negedge clk_pix);

        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_de_u%0d", k), 32'(obs_de[k]), 32'd0);
            chk($sformatf("rst_r_u%0d",  k), 32'(obs_r[k]),  32'd0);
            chk($sformatf("rst_x_u%0d",  k), 32'(obs_x[k]),  32'd0);
            chk($sformatf("rst_fc_u%0d", k), 32'(obs_fc[k]), 32'd0);
            chk($sformatf("rst_fs_u%0d", k), obs_fs[k],      32'd0);
            chk($sformatf("rst_sv_u%0d", k), 32'(obs_sv[k]), 32'd0);
        end
        rst_pix = 1'b1;

        // Widening 5->8 and 3->8
        step(0, 0, 1, 0, 0, 0, 0);    idle(1); chk("w58_00", 32'(obs_r[0]), 32'h00);
        step(1, 0, 1, 0, 31, 31, 31); idle(1); chk("w58_31", 32'(obs_r[0]), 32'hFF);
        step(2, 0, 1, 0, 16, 16, 16); idle(1); chk("w58_16", 32'(obs_r[0]), 32'h84);
        step(3, 0, 1, 0, 5, 5, 5);    idle(1); chk("w38_5",  32'(obs_r[5]), 32'hB6);

        // Narrowing 8->5: round saturates, round vs truncate
        step(0, 0, 1, 0, 'hFF, 'hFF, 'hFF); idle(2); chk("rnd_ff", 32'(obs_r[2]), 32'd31);
        step(0, 0, 1, 0, 'h84, 'h84, 'h84); idle(2);
        chk("rnd_84", 32'(obs_r[2]), 32'd17);
        chk("trc_84", 32'(obs_r[3]), 32'd16);

        // Ordered dither over the four Bayer positions
        for (int i = 0; i < 4; i++) begin
            step(i & 1, i >> 1, 1, 0, 'h86, 'h86, 'h86); idle(2);
            chk($sformatf("dith86_p%0d", i), 32'(obs_r[4]), (i == 0) ? 32'd16 : 32'd17);
        end
        for (int i = 0; i < 4; i++) begin
            step(i & 1, i >> 1, 1, 0, 0, 0, 0); idle(2);
            chk($sformatf("dith00_p%0d", i), 32'(obs_r[4]), 32'd0);
        end

        // PIPE=3 latency of the frame pulse, and blanking of colour while de is low
        step(5, 7, 0, 1, 31, 31, 31);
        idle(2); chk("lat_fr_t2", 32'(obs_fr[1]), 32'd0);
        idle(1); chk("lat_fr_t3", 32'(obs_fr[1]), 32'd1);
        chk("blank_r", 32'(obs_r[1]), 32'd0);
        chk("lat_x",   32'(obs_x[1]), 32'd5);
        idle(1); chk("lat_fr_t4", 32'(obs_fr[1]), 32'd0);

        // Asynchronous reset in the middle of a frame
        step(0, 0, 1, 1, 31, 31, 31);
        step(1, 0, 1, 0, 31, 31, 31);
        step(2, 0, 1, 0, 31, 31, 31);
        #2 rst_pix = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("arst_de_u%0d", k), 32'(obs_de[k]), 32'd0);
            chk($sformatf("arst_r_u%0d",  k), 32'(obs_r[k]),  32'd0);
            chk($sformatf("arst_fc_u%0d", k), 32'(obs_fc[k]), 32'd0);
        end
        sb.delete();
        @(negedge clk_pix);
        rst_pix = 1'b1;

        // Three frames of 4x2 white pixels on the 5->8 PIPE=3 build
        for (int fr = 0; fr < 3; fr++) begin
            for (int p = 0; p < 10; p++) begin
                if (p < 8) step(p % 4, p / 4, 1, p == 0, 31, 31, 31);
                else       step(p, 2, 0, 0, 0, 0, 0);
                if (p == 4) begin
                    chk($sformatf("fc_f%0d", fr), 32'(obs_fc[1]), 32'(fr + 1));
                    chk($sformatf("sv_f%0d", fr), 32'(obs_sv[1]), (fr > 0) ? 32'd1 : 32'd0);
                    chk($sformatf("fs_f%0d", fr), obs_fs[1], (fr > 0) ? 32'd6120 : 32'd0);
                end
                if (p == 5) begin
                    chk($sformatf("sv_drop_f%0d", fr), 32'(obs_sv[1]), 32'd0);
                    chk($sformatf("fs_hold_f%0d", fr), obs_fs[1], (fr > 0) ? 32'd6120 : 32'd0);
                end
            end
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_pix);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_adapt.md
Name: disp_adapt

Overview:
- Parametrised display output adapter between a chapter core's display outputs and the board/SDL video sink.
- Converts each colour channel from BPC_IN to BPC_OUT bits by bit replication, truncation, rounding or 2x2 ordered dither.
- Delays coordinates, de and frame through a configurable pipeline so they stay aligned with the converted colour.
- Produces a frame counter and per-frame pixel checksum, so Verilator and hardware benches can check frames without dumping images.

Parameters:
- BPC_IN, 5, input bits per colour channel (1..12).
- BPC_OUT, 8, output bits per colour channel (1..12).
- CORDW, 16, signed coordinate width (bits).
- PIPE, 2, total latency in clk_pix cycles (1..4).
- MODE, 2, narrowing mode when BPC_OUT<BPC_IN: 0=truncate, 1=round, 2=ordered dither. Ignored when widening or equal.

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix  in  1  asynchronous, active-low reset.
- in_x  in  CORDW  signed horizontal position.
- in_y  in  CORDW  signed vertical position.
- in_de  in  1  data enable.
- in_frame  in  1  one-cycle frame-start pulse.
- in_r/in_g/in_b  in  BPC_IN each  colour channels.
- out_x/out_y  out  CORDW  delayed positions.
- out_de/out_frame  out  1  delayed de and frame.
- out_r/out_g/out_b  out  BPC_OUT each  converted colour, zero when out_de low.
- frame_count  out  16  count of out_frame pulses, wraps.
- frame_sum  out  32  checksum of the last complete frame.
- sum_valid  out  1  one-cycle pulse when frame_sum updates.

Behaviour:
- Clock and reset: one clock, clk_pix. Reset is asynchronous and active-low on rst_pix. While rst_pix is low, all pipeline registers and outputs are 0, including frame_count, frame_sum, sum_valid and the internal primed flag.
- Latency: every out_* equals the corresponding in_* from exactly PIPE cycles earlier. Conversion happens in stage 1; the remaining stages are plain delay.
- Widen (BPC_OUT>BPC_IN): the output is the input repeated MSB-first and truncated to BPC_OUT. Example, 5->8: {c, c[4:2]}. Examples, 3->8: {c, c, c[2:1]}. 0 maps to 0; all-ones maps to all-ones.
- Equal width: passthrough.
- Narrow: let D = BPC_IN-BPC_OUT.
  - MODE 0: drop the low D bits.
  - MODE 1: add 2^(D-1), saturate at 2^BPC_IN-1, then drop D bits.
  - MODE 2: b = {x[0]^y[0], y[0]} from in_x/in_y, giving Bayer values 0,2,3,1. Threshold t = b<<(D-2) when D>=2, else b>>1. Add t, saturate, drop D bits.
- Any unrecognised MODE value behaves as MODE 0.
- Blanking: out_r/g/b are forced to 0 in any cycle where out_de is 0.
- Checksum accumulator: 32-bit acc, which adds out_r+out_g+out_b (zero-extended) on each out_de cycle and wraps mod 2^32.
- On an out_frame cycle:
  - frame_count increments, wrapping at 0xFFFF->0.
  - If primed: frame_sum <= acc and sum_valid=1 for that single cycle.
  - acc reloads with this cycle's pixel contribution if out_de, else 0.
  - primed <= 1.
- First frame after reset: the first out_frame does not assert sum_valid, because the preceding partial frame is discarded.
- sum_valid is never high for two consecutive cycles. frame_sum holds its value between pulses.
- Reset mid-frame: the pipeline flushes immediately and primed clears. After release, outputs reflect new inputs after PIPE cycles.

Decomposition:
- A shared include holds the mode constants (DISP_MODE_TRUNC=0, DISP_MODE_ROUND=1, DISP_MODE_DITHER=2) and the 2x2 Bayer ordering. Later chapter tops and benches reuse the same codes.
- One sub-module, disp_chan_conv: a combinational single-channel converter with BPC_IN, BPC_OUT, MODE parameters and x0/y0 inputs.
- disp_chan_conv is instantiated three times. disp_adapt owns all registers, the pipeline and the checksum.

Test Plan:
- Widen 5->8, PIPE=1: in_r=0, 31, 16 with de=1 -> out_r=0x00, 0xFF, 0x84 one cycle later. A 3->8 build maps c=5 to 0xB6.
- Narrow 8->5 round: in=0xFF -> 31 (saturated); 0x84 -> 17. In truncate mode, 0x84 -> 16.
- Dither 8->5: constant 0x86 at (x,y)=(0,0),(1,0),(0,1),(1,1) -> 16, 17, 17, 17. Constant 0x00 -> 0 everywhere.
- Latency and blanking, PIPE=3: in_frame at cycle t -> out_frame at t+3. de=0 with in_r=31 -> out_r=0.
- Checksum, 5->8: three frames of 4x2 active pixels, all r=g=b=31.
  - First out_frame: frame_count=1, sum_valid=0.
  - Second: frame_sum=6120 with a one-cycle sum_valid.
  - Third: 6120 again; frame_count=3.
- Reset: assert rst_pix low mid-frame -> all outputs 0 the same cycle (asynchronous). After release, the first out_frame gives no sum_valid.
